cat_recognizer_ctrl: RTL

Sequencer for the cat-recognizer inference datapath. On a start command it walks the pixel words in the register file and the matching weight words, and accumulates the dot product into a 64-bit signed accumulator. It then drives the CatRecOut decision. It shares the register-file read port with the APB slave; APB always has priority, and the controller stalls while APB holds the port.

---
 rtl/cat_recognizer_ctrl_pkg.sv | 22 ++
 rtl/cat_recognizer_ctrl_mac_unit.sv | 28 ++
 rtl/cat_recognizer_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/cat_recognizer_ctrl_pkg.sv
// Shared types and constants for the cat-recognizer inference sequencer.
// Holds the FSM state encoding and the weight-channel sign-extension helper.
package cat_rec_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        DRAIN  = 3'd3,
        DECIDE = 3'd4
    } state_t;

    localparam int ACC_W     = 64;
    localparam int CTRL_ADDR = 0;
    localparam int START_BIT = 0;

    // Weight channels are wp-bit two's complement, right-aligned in raw.
    function automatic logic signed [15:0] sext_weight(input logic [15:0] raw, input int wp);
        return $signed(raw << (16 - wp)) >>> (16 - wp);
    endfunction

endpackage

// File: rtl/cat_recognizer_ctrl_mac_unit.sv
// Combinational three-channel multiply-and-sum: unsigned 8-bit pixel channels
// times signed weight channels, summed into one sign-extended accumulator term.
module cat_mac_unit
    import cat_rec_ctrl_pkg::*;
#(
    parameter int Amba_Word        = 24,
    parameter int Weight_precision = 5
) (
    input  logic [Amba_Word-1:0]          pix_data,
    input  logic [3*Weight_precision-1:0] w_data,
    output logic signed [ACC_W-1:0]       term
);

    localparam int WP = Weight_precision;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic signed [15:0] p16;
        logic signed [15:0] w16;
        logic signed [31:0] prod;

        assign p16  = {8'd0, pix_data[8*c +: 8]};
        assign w16  = sext_weight(16'(w_data[WP*c +: WP]), WP);
        assign prod = p16 * w16;
    end

    assign term = ACC_W'(g_ch[0].prod) + ACC_W'(g_ch[1].prod) + ACC_W'(g_ch[2].prod);

endmodule

// File: rtl/cat_recognizer_ctrl.sv
// Inference sequencer: walks pixel/weight words, accumulates the dot product,
// and decides CatRecOut. Yields the shared read port to APB whenever mem_grant=0.
module cat_recognizer_ctrl
    import cat_rec_ctrl_pkg::*;
#(
    parameter int Amba_Word        = 24,
    parameter int Amba_Addr_Depth  = 13,
    parameter int Weight_precision = 5,
    parameter int Pixel_Count      = 4096,
    parameter int Pixel_Base       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mem_grant,
    output logic                            pix_rd,
    output logic [Amba_Addr_Depth-1:0]      pix_addr,
    input  logic [Amba_Word-1:0]            pix_data,
    output logic [Amba_Addr_Depth-1:0]      w_addr,
    input  logic [3*Weight_precision-1:0]   w_data,
    output logic                            busy,
    output logic                            done,
    output logic signed [ACC_W-1:0]         acc_val,
    output logic signed [ACC_W-1:0]         last_result,
    output logic                            CatRecOut,
    output state_t                          fsm_state
);

    localparam int AD = Amba_Addr_Depth;
    localparam logic [AD-1:0] LAST_IDX = AD'(Pixel_Count - 1);
    localparam logic [AD-1:0] BASE     = AD'(Pixel_Base);

    state_t                   state;
    logic                     valid;
    logic signed [ACC_W-1:0]  term;

    cat_mac_unit #(
        .Amba_Word        (Amba_Word),
        .Weight_precision (Weight_precision)
    ) u_mac (
        .pix_data (pix_data),
        .w_data   (w_data),
        .term     (term)
    );

    // The read strobe must follow mem_grant within the same cycle.
    assign pix_rd    = (state == FETCH) && mem_grant;
    assign fsm_state = state;

    // w_addr doubles as the word index; pix_addr always tracks it at +Pixel_Base.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            CatRecOut   <= 1'b0;
            acc_val     <= '0;
            last_result <= '0;
            pix_addr    <= '0;
            w_addr      <= '0;
            valid       <= 1'b0;
        end else begin
            valid <= pix_rd;
            done  <= 1'b0;
            if (valid) begin
                acc_val <= acc_val + term;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    acc_val   <= '0;
                    CatRecOut <= 1'b0;
                    pix_addr  <= BASE;
                    w_addr    <= '0;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (mem_grant) begin
                        pix_addr <= pix_addr + 1'b1;
                        w_addr   <= w_addr + 1'b1;
                        if (w_addr == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= DECIDE;
                    done  <= 1'b1;
                end
                DECIDE: begin
                    last_result <= acc_val;
                    CatRecOut   <= (acc_val > 0);
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
